decode_sequencer: RTL and testbench
===================================

// Module: decode_sequencer
// PURPOSE
//  Top-level decode controller. Accepts 16-bit host commands and gates the encoded bit stream into the
//  number generator, which feeds the table generator, the IDCT and the image/histogram generators.
//  Tracks 8x8 block position and image-RAM base address from IDCT completion pulses.
//  After the last block it fires a one-cycle CDF start to the histogram generator, waits for its done,
//  and reports status.
// PARAMETERS
//  IMAGE_WIDTH              320     image width, pixels (multiple of BLOCK_DIM)
//  IMAGE_HEIGHT             240     image height, pixels (multiple of BLOCK_DIM)
//  BLOCK_DIM                8       block edge, pixels
//  IMAGE_RAM_ADDRESS_WIDTH  17      = clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
//  CDF_TIMEOUT              4096    max cycles in CDF_WAIT before error
// PORTS
//  clk                  in   1     clock
//  rst                  in   1     synchronous reset, active high
//  command              in   16    host command; opcode = command[15:12]
//  command_valid        in   1     command qualifier, one cycle
//  block_valid          in   1     IDCT m_valid: one block finished
//  cdf_done             in   1     histogram generator CDF pass complete (pulse)
//  bit_enable           out  1     1 = pass is_new to number generator
//  block_x              out  clog2(IMAGE_WIDTH/BLOCK_DIM)    column of block in flight
//  block_y              out  clog2(IMAGE_HEIGHT/BLOCK_DIM)   row of block in flight
//  block_base_address   out  IMAGE_RAM_ADDRESS_WIDTH  = block_y*BLOCK_DIM*IMAGE_WIDTH + block_x*BLOCK_DIM
//  start_cdf            out  1     one-cycle pulse to histogram generator
//  busy                 out  1     state not IDLE/DONE
//  done                 out  1     sticky; image complete
//  error                out  1     sticky; protocol violation or timeout
// BEHAVIOUR
//  Derived constants:
//   BX = IMAGE_WIDTH/BLOCK_DIM
//   BY = IMAGE_HEIGHT/BLOCK_DIM
//  Opcodes:
//   4'h1 START
//   4'h2 ABORT
//   4'h3 CLEAR
//   others ignored, no error
//  Reset: state=IDLE; all outputs 0; block_x/block_y/base/timeout counter = 0.
//  All outputs are registered and change the cycle after the causing input.
//  IDLE:
//   START -> DECODE; clears x, y, base, done, error.
//   CLEAR -> clears done/error.
//  DECODE:
//   bit_enable=1, busy=1.
//   Each block_valid advances x.
//   At x=BX-1, x wraps to 0 and y increments.
//   base tracks (x,y) incrementally: +BLOCK_DIM normally; +(BLOCK_DIM-1)*IMAGE_WIDTH+BLOCK_DIM on row wrap.
//   block_valid at x=BX-1, y=BY-1 -> CDF_START; bit_enable=0 from the next cycle; x, y hold at last block.
//  CDF_START:
//   start_cdf=1 for exactly one cycle -> CDF_WAIT.
//   Timeout counter cleared.
//  CDF_WAIT:
//   cdf_done -> DONE.
//   Counter reaching CDF_TIMEOUT-1 without cdf_done -> DONE with error=1.
//  DONE:
//   done=1, busy=0.
//   START restarts as from IDLE.
//   CLEAR -> IDLE, done=0, error=0.
//  ABORT in DECODE/CDF_START/CDF_WAIT -> IDLE next cycle.
//   bit_enable=0, x=y=base=0, done=0, error unchanged.
//   ABORT in IDLE or DONE: ignored.
//  Errors (sticky):
//   START while busy: ignored, sets error.
//   block_valid outside DECODE: ignored, sets error.
//   cdf_done outside CDF_WAIT: ignored, sets error.
//  Simultaneous events:
//   ABORT + block_valid: ABORT wins; block not counted.
//   cdf_done + timeout in the same cycle: cdf_done wins, no error.
//  rst mid-operation: synchronous return to reset values regardless of state; no start_cdf pulse emitted.
// TESTING
//  1. IMAGE_WIDTH=IMAGE_HEIGHT=16; START, then 4 block_valid
//     -> base 0,8,128,136; bit_enable falls after 4th; start_cdf 1 cycle; cdf_done -> done=1, error=0.
//  2. Default params, 1200 block_valid
//     -> row wrap at 40th (x=0, y=1, base=2560); last base=74552 (x=39, y=29); single start_cdf.
//  3. START, 3 blocks, ABORT same cycle as 4th block_valid
//     -> IDLE, x=y=base=0, busy=0, error=0; fresh START decodes normally.
//  4. START twice in DECODE; block_valid in IDLE
//     -> error=1 each case, state unchanged; CLEAR in IDLE clears error.
//  5. CDF_TIMEOUT=16, cdf_done withheld
//     -> DONE at 16th CDF_WAIT cycle, done=1, error=1; cdf_done on that exact cycle -> error=0.
//  6. rst asserted in CDF_WAIT and in DECODE -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/decode_sequencer.sv
// Decode controller: gates the bit stream during DECODE, walks 8x8 block positions and image-RAM
// base addresses on IDCT completions, then runs one CDF pass with a timeout and reports status.
module decode_sequencer #(
  parameter int IMAGE_WIDTH             = 320,
  parameter int IMAGE_HEIGHT            = 240,
  parameter int BLOCK_DIM               = 8,
  parameter int IMAGE_RAM_ADDRESS_WIDTH = 17,
  parameter int CDF_TIMEOUT             = 4096,
  localparam int BX = IMAGE_WIDTH / BLOCK_DIM,
  localparam int BY = IMAGE_HEIGHT / BLOCK_DIM,
  localparam int XW = (BX > 1) ? $clog2(BX) : 1,
  localparam int YW = (BY > 1) ? $clog2(BY) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [15:0]                        command,
  input  logic                               command_valid,
  input  logic                               block_valid,
  input  logic                               cdf_done,
  output logic                               bit_enable,
  output logic [XW-1:0]                      block_x,
  output logic [YW-1:0]                      block_y,
  output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] block_base_address,
  output logic                               start_cdf,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [2:0]                         fsm_state
);

  // Handshake: command_valid, block_valid and cdf_done are single-cycle qualifiers with no
  // back-pressure; every input event is consumed (or flagged as an error) on the edge it is seen.

  localparam int AW = IMAGE_RAM_ADDRESS_WIDTH;
  localparam int TW = (CDF_TIMEOUT > 1) ? $clog2(CDF_TIMEOUT) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(BX - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(BY - 1);
  localparam logic [AW-1:0] STEP_COL = AW'(BLOCK_DIM);
  localparam logic [AW-1:0] STEP_ROW = AW'((BLOCK_DIM - 1) * IMAGE_WIDTH + BLOCK_DIM);
  localparam logic [TW-1:0] T_LAST   = TW'(CDF_TIMEOUT - 1);

  localparam logic [3:0] OP_START = 4'h1;
  localparam logic [3:0] OP_ABORT = 4'h2;
  localparam logic [3:0] OP_CLEAR = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_CDF_START = 3'd2,
    S_CDF_WAIT  = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   base_q, base_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            bit_enable_q, start_cdf_q, busy_q;

  logic            cmd_start, cmd_abort, cmd_clear;
  logic            in_busy;
  logic            cmd_unused;

  assign cmd_start  = command_valid && (command[15:12] == OP_START);
  assign cmd_abort  = command_valid && (command[15:12] == OP_ABORT);
  assign cmd_clear  = command_valid && (command[15:12] == OP_CLEAR);
  assign cmd_unused = ^command[11:0];
  assign in_busy    = (state_q == S_DECODE) || (state_q == S_CDF_START) ||
                      (state_q == S_CDF_WAIT);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    tmo_d   = tmo_q;
    done_d  = done_q;
    error_d = error_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cmd_start) begin
          state_d = S_DECODE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end else if (cmd_clear) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end

      S_DECODE: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          done_d  = 1'b0;
        end else if (block_valid) begin
          if (x_q == X_LAST) begin
            // The final block leaves x/y/base parked on itself while the CDF pass runs.
            if (y_q == Y_LAST) begin
              state_d = S_CDF_START;
            end else begin
              x_d    = '0;
              y_d    = y_q + YW'(1);
              base_d = base_q + STEP_ROW;
            end
          end else begin
            x_d    = x_q + XW'(1);
            base_d = base_q + STEP_COL;
          end
        end
      end

      S_CDF_START: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          done_d  = 1'b0;
        end else begin
          state_d = S_CDF_WAIT;
          tmo_d   = '0;
        end
      end

      S_CDF_WAIT: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          done_d  = 1'b0;
        end else if (cdf_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (tmo_q == T_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Protocol violations are applied after any START/CLEAR clear in the same cycle.
    if ((cmd_start && in_busy) ||
        (block_valid && (state_q != S_DECODE)) ||
        (cdf_done && (state_q != S_CDF_WAIT))) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      tmo_q        <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      bit_enable_q <= 1'b0;
      start_cdf_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      base_q       <= base_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      error_q      <= error_d;
      bit_enable_q <= (state_d == S_DECODE);
      start_cdf_q  <= (state_d == S_CDF_START);
      busy_q       <= (state_d == S_DECODE) || (state_d == S_CDF_START) ||
                      (state_d == S_CDF_WAIT);
    end
  end

  assign bit_enable         = bit_enable_q;
  assign block_x            = x_q;
  assign block_y            = y_q;
  assign block_base_address = base_q;
  assign start_cdf          = start_cdf_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign fsm_state          = state_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: directed scenarios plus random traffic, every cycle compared against
// a block-index / cycle-count reference model.
module tb_decode_sequencer;

  localparam int IW  = 40;
  localparam int IH  = 24;
  localparam int BD  = 8;
  localparam int AW  = 10;
  localparam int TMO = 16;
  localparam int BX  = IW / BD;
  localparam int BY  = IH / BD;
  localparam int NB  = BX * BY;
  localparam int XW  = (BX > 1) ? $clog2(BX) : 1;
  localparam int YW  = (BY > 1) ? $clog2(BY) : 1;

  localparam int M_IDLE = 0, M_DECODE = 1, M_CSTART = 2, M_CWAIT = 3, M_DONE = 4;
  localparam logic [3:0] OP_NONE = 4'h0, OP_START = 4'h1, OP_ABORT = 4'h2, OP_CLEAR = 4'h3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]   command = '0;
  logic          command_valid = 1'b0, block_valid = 1'b0, cdf_done = 1'b0;
  logic          bit_enable, start_cdf, busy, done, error;
  logic [XW-1:0] block_x;
  logic [YW-1:0] block_y;
  logic [AW-1:0] block_base_address;
  logic [2:0]    fsm_state;

  decode_sequencer #(
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .BLOCK_DIM(BD),
    .IMAGE_RAM_ADDRESS_WIDTH(AW), .CDF_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .command(command), .command_valid(command_valid),
    .block_valid(block_valid), .cdf_done(cdf_done), .bit_enable(bit_enable),
    .block_x(block_x), .block_y(block_y), .block_base_address(block_base_address),
    .start_cdf(start_cdf), .busy(busy), .done(done), .error(error), .fsm_state(fsm_state)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  int m_mode = M_IDLE, m_n = 0, m_wait = 0;
  bit m_done = 0, m_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_base(input int n);
    return (n / BX) * BD * IW + (n % BX) * BD;
  endfunction

  task automatic model_step(input bit r, input logic [3:0] op, input bit cv, input bit bv,
                            input bit cd);
    bit start, abort, clear, was_busy, viol;
    if (r) begin
      m_mode = M_IDLE; m_n = 0; m_wait = 0; m_done = 0; m_err = 0;
      return;
    end
    start    = cv && (op == OP_START);
    abort    = cv && (op == OP_ABORT);
    clear    = cv && (op == OP_CLEAR);
    was_busy = (m_mode == M_DECODE) || (m_mode == M_CSTART) || (m_mode == M_CWAIT);
    viol     = (start && was_busy) || (bv && m_mode != M_DECODE) || (cd && m_mode != M_CWAIT);
    if (abort && was_busy) begin
      m_mode = M_IDLE; m_n = 0; m_done = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (start) begin
            m_mode = M_DECODE; m_n = 0; m_done = 0; m_err = 0;
          end else if (clear) begin
            m_mode = M_IDLE; m_done = 0; m_err = 0;
          end
        end
        M_DECODE: if (bv) begin
          if (m_n == NB - 1) begin
            m_mode = M_CSTART;
            exp_q.push_back(32'(exp_base(m_n)));
          end else m_n++;
        end
        M_CSTART: begin m_mode = M_CWAIT; m_wait = 0; end
        M_CWAIT: begin
          if (cd) begin
            m_mode = M_DONE; m_done = 1;
          end else begin
            m_wait++;
            if (m_wait == TMO) begin m_mode = M_DONE; m_done = 1; m_err = 1; end
          end
        end
        default: ;
      endcase
    end
    if (viol) m_err = 1;
  endtask

  task automatic compare_all();
    check_eq("bit_enable", 32'(bit_enable), 32'(m_mode == M_DECODE));
    check_eq("busy", 32'(busy), 32'(m_mode == M_DECODE || m_mode == M_CSTART || m_mode == M_CWAIT));
    check_eq("start_cdf", 32'(start_cdf), 32'(m_mode == M_CSTART));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("error", 32'(error), 32'(m_err));
    check_eq("block_x", 32'(block_x), 32'(m_n % BX));
    check_eq("block_y", 32'(block_y), 32'(m_n / BX));
    check_eq("block_base", 32'(block_base_address), 32'(exp_base(m_n)));
    if (start_cdf === 1'b1) begin
      check_eq("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("pulse_base", 32'(block_base_address), exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic tick(input bit r, input logic [3:0] op, input bit cv, input bit bv, input bit cd);
    rst           = r;
    command       = {op, 12'($urandom)};
    command_valid = cv;
    block_valid   = bv;
    cdf_done      = cd;
    @(posedge clk);
    model_step(r, op, cv, bv, cd);
    #1 compare_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(0, OP_NONE, 0, 0, 0);
  endtask

  task automatic cmd(input logic [3:0] op);
    tick(0, op, 1, 0, 0);
  endtask

  task automatic feed_blocks(input int max_blocks);
    int fed;
    fed = 0;
    for (int i = 0; i < 4 * NB + 8 && m_mode == M_DECODE && fed < max_blocks; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        tick(0, OP_NONE, 0, 1, 0);
        fed++;
      end else idle(1);
    end
  endtask

  task automatic random_traffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      logic [3:0] op;
      bit r, cv, bv, cd;
      int sel;
      sel = $urandom_range(0, 19);
      op  = (sel < 8) ? OP_START : (sel < 12) ? OP_ABORT : (sel < 17) ? OP_CLEAR : 4'($urandom);
      cv  = ($urandom_range(0, 11) == 0);
      bv  = (m_mode == M_DECODE) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 30) == 0);
      cd  = (m_mode == M_CWAIT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 60) == 0);
      r   = ($urandom_range(0, 499) == 0);
      tick(r, op, cv, bv, cd);
    end
  endtask

  initial begin
    // reset
    tick(1, OP_NONE, 0, 0, 0);
    tick(1, OP_NONE, 0, 0, 0);
    idle(2);

    // full image, row wraps, single start_cdf, cdf_done after a short wait
    cmd(OP_START);
    feed_blocks(NB);
    idle(3);
    tick(0, OP_NONE, 0, 0, 1);
    check_eq("image_done", 32'(done), 32'd1);
    idle(2);
    cmd(OP_CLEAR);

    // ABORT on the same cycle as a block, then a fresh decode
    cmd(OP_START);
    feed_blocks(3);
    tick(0, OP_ABORT, 1, 1, 0);
    idle(1);
    cmd(OP_START);
    feed_blocks(NB);
    idle(1);
    tick(0, OP_NONE, 0, 0, 1);

    // protocol errors: START while busy, block outside DECODE, cdf_done outside CDF_WAIT
    cmd(OP_START);
    feed_blocks(2);
    cmd(OP_START);
    cmd(OP_START);
    tick(0, OP_NONE, 0, 0, 1);
    cmd(OP_ABORT);
    tick(0, OP_NONE, 0, 1, 0);
    cmd(4'h7);
    cmd(OP_CLEAR);
    idle(1);

    // CDF timeout, then cdf_done on the final permitted cycle
    cmd(OP_START);
    feed_blocks(NB);
    for (int i = 0; i < TMO + 8 && m_mode != M_DONE; i++) idle(1);
    check_eq("timeout_error", 32'(error), 32'd1);
    cmd(OP_CLEAR);
    cmd(OP_START);
    feed_blocks(NB);
    idle(1);
    for (int i = 0; i < TMO + 8 && m_mode == M_CWAIT && m_wait < TMO - 1; i++) idle(1);
    tick(0, OP_NONE, 0, 0, 1);
    check_eq("late_done_no_error", 32'(error), 32'd0);
    cmd(OP_START);

    // reset in DECODE and in CDF_WAIT
    feed_blocks(2);
    tick(1, OP_NONE, 0, 0, 0);
    cmd(OP_START);
    feed_blocks(NB);
    idle(3);
    tick(1, OP_NONE, 0, 0, 0);
    idle(2);

    random_traffic(5000);

    idle(2);
    check_eq("pulse_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
